// File: rtl/enc42_pkg.sv
// Shared types and helpers for the registered 4-to-2 request encoder.
// Optional feature macro: ENC42_RR_EN (round-robin selection).
package enc42_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // One-hot request mask for a 2-bit index
  function automatic logic [N_REQ-1:0] onehot2(input logic [IDX_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/enc_4_2_pick.sv
// Combinational selector: picks one pending request index.
// ENC42_RR_EN defined: round-robin search starting after ptr.
// ENC42_RR_EN undefined: fixed priority, p3 highest.
module enc_4_2_pick
  import enc42_pkg::*;
(
`ifdef ENC42_RR_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  input  logic [N_REQ-1:0] pend,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

`ifdef ENC42_RR_EN
  logic [IDX_W-1:0] w_cand;

  // Search ptr+1, ptr+2, ptr+3, ptr (mod 4); first pending hit wins
  always_comb begin
    idx    = '0;
    any    = 1'b0;
    w_cand = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_cand = ptr + IDX_W'(k);
      if (!any && pend[w_cand]) begin
        idx = w_cand;
        any = 1'b1;
      end
    end
  end
`else
  // Fixed priority encoder, p3 > p2 > p1 > p0
  always_comb begin
    idx = '0;
    any = |pend;
    if (pend[3])      idx = 2'd3;
    else if (pend[2]) idx = 2'd2;
    else if (pend[1]) idx = 2'd1;
    else              idx = 2'd0;
  end
`endif

endmodule

// File: rtl/enc_4_2_seq.sv
// Registered 4-to-2 request encoder with valid/ack output handshake.
// Requests are latched into a pending register; one pending index is
// presented on a1,a0 with valid and held until ack.
// Optional feature macro: ENC42_RR_EN (round-robin instead of fixed priority).
module enc_4_2_seq
  import enc42_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       En,
  input  logic       d3,
  input  logic       d2,
  input  logic       d1,
  input  logic       d0,
  input  logic       ack,
  output logic       a1,
  output logic       a0,
  output logic       valid,
  output logic [3:0] pend
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_REQ-1:0] r_pend;
  logic [N_REQ-1:0] w_pend_nxt;
  logic [N_REQ-1:0] w_clr;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
`ifdef ENC42_RR_EN
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;
`endif

  // Selection looks only at the registered pending bits
  enc_4_2_pick u_pick (
`ifdef ENC42_RR_EN
    .ptr  (r_ptr),
`endif
    .pend (r_pend),
    .idx  (w_pick_idx),
    .any  (w_pick_any)
  );

  // Pending update: clear the acknowledged bit, new requests set (set wins)
  always_comb begin
    w_clr      = (r_valid && ack) ? onehot2(r_idx) : '0;
    w_pend_nxt = (r_pend & ~w_clr) | ({d3, d2, d1, d0} & {N_REQ{En}});
  end

  // Next-state and next-output logic for the handshake FSM
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
`ifdef ENC42_RR_EN
    w_ptr_nxt   = r_ptr;
`endif
    case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
        if (w_pick_any) begin
          w_idx_nxt   = w_pick_idx;
          w_valid_nxt = 1'b1;
          w_state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = IDLE;
`ifdef ENC42_RR_EN
          w_ptr_nxt   = r_idx;
`endif
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, pending and output registers; async reset clears everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
`ifdef ENC42_RR_EN
      r_ptr   <= '1;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
`ifdef ENC42_RR_EN
      r_ptr   <= w_ptr_nxt;
`endif
    end
  end

  assign a1    = r_idx[1];
  assign a0    = r_idx[0];
  assign valid = r_valid;
  assign pend  = r_pend;

endmodule

// File: tb/tb_enc_4_2_seq.sv
// Self-checking bench for enc_4_2_seq: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_enc_4_2_seq;

  logic clk;
  logic rst_n;
  logic En, d3, d2, d1, d0, ack;
  logic a1, a0, valid;
  logic [3:0] pend;

  int tests = 0;
  int fails = 0;

  // behavioural model state
  logic [3:0] m_pend;
  logic       m_valid;
  int         m_idx;
`ifdef ENC42_RR_EN
  int         m_ptr;
`endif

  enc_4_2_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .En    (En),
    .d3    (d3),
    .d2    (d2),
    .d1    (d1),
    .d0    (d0),
    .ack   (ack),
    .a1    (a1),
    .a0    (a0),
    .valid (valid),
    .pend  (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int choose(input logic [3:0] p);
`ifdef ENC42_RR_EN
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (p[c]) return c;
    end
`else
    for (int c = 3; c >= 0; c--) begin
      if (p[c]) return c;
    end
`endif
    return 0;
  endfunction

  task automatic model_reset();
    m_pend  = 4'b0000;
    m_valid = 1'b0;
    m_idx   = 0;
`ifdef ENC42_RR_EN
    m_ptr   = 3;
`endif
  endtask

  // One clock edge of the model, using the inputs present at that edge
  task automatic model_edge();
    logic [3:0] clr;
    logic [3:0] nxt;
    clr = (m_valid && ack) ? (4'b0001 << m_idx) : 4'b0000;
    nxt = (m_pend & ~clr) | (En ? {d3, d2, d1, d0} : 4'b0000);
    if (!m_valid) begin
      if (m_pend != 4'b0000) begin
        m_idx   = choose(m_pend);
        m_valid = 1'b1;
      end
    end else if (ack) begin
      m_valid = 1'b0;
`ifdef ENC42_RR_EN
      m_ptr   = m_idx;
`endif
    end
    m_pend = nxt;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("pend", pend, m_pend);
    check("valid", {3'b000, valid}, {3'b000, m_valid});
    if (m_valid) check("index", {2'b00, a1, a0}, 4'(m_idx));
  endtask

  task automatic cycle(input logic en, input logic [3:0] d, input logic a);
    En = en;
    {d3, d2, d1, d0} = d;
    ack = a;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    rst_n = 1'b0;
    En = 1'b0; {d3, d2, d1, d0} = 4'b0000; ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_pend", pend, 4'b0000);
    check("reset_out", {1'b0, valid, a1, a0}, 4'b0000);

    // single pulse on d2, ack held high
    cycle(1'b1, 4'b0100, 1'b1);
    check("pulse_pend", pend, 4'b0100);
    cycle(1'b0, 4'b0000, 1'b1);
    check("pulse_valid_idx", {1'b0, valid, a1, a0}, 4'b0110);
    cycle(1'b0, 4'b0000, 1'b1);
    check("pulse_drained", {valid, 3'b000} | pend, 4'b0000);
    cycle(1'b0, 4'b0000, 1'b0);

    // all four requests at once, ack always high
    cycle(1'b1, 4'b1111, 1'b1);
    repeat (9) cycle(1'b0, 4'b0000, 1'b1);

    // En low drops requests, then a real d1 request
    repeat (3) cycle(1'b0, 4'b0010, 1'b0);
    check("en_low_pend", pend, 4'b0000);
    cycle(1'b1, 4'b0010, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    check("en_high_idx", {1'b0, valid, a1, a0}, 4'b0101);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b0);

    // hold without ack while another request arrives
    cycle(1'b1, 4'b0001, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b1, 4'b1000, 1'b0);
    check("hold_pend", pend, 4'b1001);
    check("hold_idx", {1'b0, valid, a1, a0}, 4'b0100);
    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b0);
    check("hold_next_idx", {1'b0, valid, a1, a0}, 4'b0111);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b0);

    // set/clear collision on bit 1
    cycle(1'b1, 4'b0010, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0010, 1'b1);
    check("collide_pend", pend, 4'b0010);
    cycle(1'b0, 4'b0000, 1'b0);
    check("collide_reassert", {1'b0, valid, a1, a0}, 4'b0101);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b0);

    // reset asserted mid-PRESENT with pend = 0110
    cycle(1'b1, 4'b0110, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    check("pre_reset_pend", pend, 4'b0110);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_out", {1'b0, valid, a1, a0}, 4'b0000);
    check("async_reset_pend", pend, 4'b0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, 4'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
